s_axis_cc_arb: RTL and testbench
================================

# s_axis_cc_arb

Packet-granular round-robin arbiter that shares the single Completer Completion (CC) AXI-Stream port of the UltraScale+ PCIe hard block among `N_REQ` completion sources. Each source is, for example, a BAR/CSR completer or a DMA completion path. The block sits in front of the CC adapter. Once a requester is granted, the grant holds until that requester's `tlast` beat is accepted, so completions are never interleaved. One registered output stage decouples timing toward the adapter.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `DATA_WIDTH`, 256: tdata width per requester and on the output.
- `KEEP_WIDTH`, DATA_WIDTH/32: one keep bit per dword.
- `USER_WIDTH`, 4: tuser width. Bit 3 is discontinue, bit 0 is ECRC request.

Ports:
- `user_clk`, in, 1: sole clock. Every signal is synchronous to it.
- `user_reset_n`, in, 1: synchronous, active-low reset.
- `s_axis_cc_tdata_req`, in, N_REQ*DATA_WIDTH: requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- `s_axis_cc_tkeep_req`, in, N_REQ*KEEP_WIDTH: per-requester keep, sliced the same way.
- `s_axis_cc_tuser_req`, in, N_REQ*USER_WIDTH: per-requester tuser.
- `s_axis_cc_tlast_req`, in, N_REQ: per-requester end of packet.
- `s_axis_cc_tvalid_req`, in, N_REQ: per-requester valid.
- `s_axis_cc_tready_req`, out, N_REQ: per-requester ready.
- `s_axis_cc_tdata`, out, DATA_WIDTH: arbitrated data.
- `s_axis_cc_tkeep`, out, KEEP_WIDTH: arbitrated keep.
- `s_axis_cc_tuser`, out, USER_WIDTH: arbitrated tuser.
- `s_axis_cc_tlast`, out, 1: arbitrated end of packet.
- `s_axis_cc_tvalid`, out, 1: arbitrated valid.
- `s_axis_cc_tready`, in, 4: downstream ready. Only bit 0 is used.
- `grant`, out, N_REQ: one-hot owner of the current packet. All zeros when idle.
- `pkt_cnt`, out, 16: count of packets whose tlast has been accepted at the output. Wraps.

## Operation
- FSM has two states.
  - IDLE: no owner.
  - PKT: one owner is locked.
- Round-robin pointer `last`, N_REQ-bit one-hot, reset value = bit N_REQ-1. Requester 0 therefore wins the first arbitration.
- In IDLE, the winner is the first requester with tvalid=1, searching from index(last)+1 modulo N_REQ. The winner is combinational in the same cycle, so its first beat can be accepted in that cycle with no bubble.
- `can_load` = !s_axis_cc_tvalid | s_axis_cc_tready[0].
- `s_axis_cc_tready_req[i]` = can_load & (state==PKT ? owner==i : winner==i). At most one bit is ever set.
- Input handshake = tvalid_req[owner] & tready_req[owner]. On each handshake:
  - The output register loads tdata/tkeep/tuser/tlast from the owner.
  - s_axis_cc_tvalid is set to 1.
- On an output handshake with no input handshake in the same cycle, s_axis_cc_tvalid goes to 0.
- IDLE→PKT: on a handshake of a non-tlast beat.
  - `owner` and `last` are set to the winner.
  - `grant` is set to the winner.
- IDLE→IDLE: on a handshake of a single-beat packet (tlast=1). `last` is updated to the winner; grant stays 0.
- PKT→IDLE: on the owner's tlast handshake. `last` keeps the owner.
- In PKT, valids from other requesters are ignored. The owner dropping tvalid mid-packet only stalls; the grant does not change.
- `pkt_cnt` increments on s_axis_cc_tvalid & s_axis_cc_tready[0] & s_axis_cc_tlast. It rolls over from 0xFFFF to 0.
- Reset mid-packet: state returns to IDLE and the output register is emptied. The partial packet is dropped downstream; upstream requesters must also be reset.
- Reset values:
  - state=IDLE, grant=0, last=bit N_REQ-1, pkt_cnt=0.
  - s_axis_cc_tvalid=0, s_axis_cc_tdata=0, s_axis_cc_tkeep=0, s_axis_cc_tuser=0, s_axis_cc_tlast=0.
  - s_axis_cc_tready_req=0 while user_reset_n=0.

## Timing
- Latency: 1 cycle from input handshake to the beat appearing on the s_axis_cc_* outputs.
- Throughput: 1 beat/cycle while s_axis_cc_tready[0]=1, including back-to-back packets from different requesters. There are zero idle cycles between packets.
- Stall: if s_axis_cc_tready[0]=0 while s_axis_cc_tvalid=1, all tready_req are 0 that cycle and the outputs hold stable.
- Output tvalid never deasserts without a handshake. Data is stable while valid & !ready.
- `grant` is registered. It goes high the cycle after the first beat is accepted and low the cycle after the tlast beat is accepted.

## Test plan
- Single requester 2 sends a 3-beat packet with tdata=beat index, ready held at 1. Required: beats 0,1,2 appear on cycles T+1..T+3; tlast is set on beat 2; grant=0100 during the packet; pkt_cnt=1.
- All 4 requesters assert a 2-beat packet simultaneously after reset. Required: output order is req 0,1,2,3; 8 consecutive valid beats with no gaps; pkt_cnt=4.
- Requester 1 is mid-packet when requester 0 raises tvalid. Required: requester 1 completes with no req0 beat interleaved; requester 0 is served immediately afterward with zero bubble.
- Downstream ready toggles 1,0,0,1 during a 4-beat packet. Required: no beat lost or duplicated; output data stays stable across the 2 stall cycles; tready_req=0 during the stalls.
- Requester 3 sends single-beat packets continuously and requester 1 sends single-beat packets continuously. Required: strict alternation 1,3,1,3… at 1 beat/cycle.
- user_reset_n is driven to 0 for 1 cycle mid-packet. Required: the next cycle shows tvalid=0, grant=0, pkt_cnt=0; the first arbitration after reset grants requester 0.

Source files
------------

// File: rtl/s_axis_cc_arb.sv
// Packet-granular round-robin arbiter sharing the PCIe CC AXI-Stream port among N_REQ sources.
// A grant holds from the first accepted beat until the owner's tlast beat, behind one output register.
module s_axis_cc_arb #(
   parameter int N_REQ      = 4,
   parameter int DATA_WIDTH = 256,
   parameter int KEEP_WIDTH = DATA_WIDTH/32,
   parameter int USER_WIDTH = 4
) (
   input  logic                          user_clk,
   input  logic                          user_reset_n,
   input  logic [N_REQ*DATA_WIDTH-1:0]   s_axis_cc_tdata_req,
   input  logic [N_REQ*KEEP_WIDTH-1:0]   s_axis_cc_tkeep_req,
   input  logic [N_REQ*USER_WIDTH-1:0]   s_axis_cc_tuser_req,
   input  logic [N_REQ-1:0]              s_axis_cc_tlast_req,
   input  logic [N_REQ-1:0]              s_axis_cc_tvalid_req,
   output logic [N_REQ-1:0]              s_axis_cc_tready_req,
   output logic [DATA_WIDTH-1:0]         s_axis_cc_tdata,
   output logic [KEEP_WIDTH-1:0]         s_axis_cc_tkeep,
   output logic [USER_WIDTH-1:0]         s_axis_cc_tuser,
   output logic                          s_axis_cc_tlast,
   output logic                          s_axis_cc_tvalid,
   input  logic [3:0]                    s_axis_cc_tready,
   output logic [N_REQ-1:0]              grant,
   output logic [15:0]                   pkt_cnt
);

   localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic {IDLE = 1'b0, PKT = 1'b1} state_t;

   state_t                 state;
   logic [IDXW-1:0]        owner;
   logic [N_REQ-1:0]       last;
   logic [IDXW-1:0]        win_idx;
   logic                   win_found;
   logic [IDXW-1:0]        sel_idx;
   logic [N_REQ-1:0]       sel_oh;
   logic                   sel_vld;
   logic                   can_load;
   logic                   in_hs;
   logic                   out_hs;
   logic [DATA_WIDTH-1:0]  tdata_p0;
   logic [KEEP_WIDTH-1:0]  tkeep_p0;
   logic [USER_WIDTH-1:0]  tuser_p0;
   logic                   tlast_p0;
   logic                   unused_tready_hi;

   assign unused_tready_hi = ^s_axis_cc_tready[3:1];

   // Round-robin search starting just after the previous winner
   always_comb begin
      int last_i;
      int j;
      last_i    = 0;
      j         = 0;
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (last[i]) last_i = i;
      end
      for (int k = 1; k <= N_REQ; k++) begin
         j = last_i + k;
         if (j >= N_REQ) j = j - N_REQ;
         if (!win_found && s_axis_cc_tvalid_req[IDXW'(j)]) begin
            win_found = 1'b1;
            win_idx   = IDXW'(j);
         end
      end
   end

   assign sel_idx  = (state == PKT) ? owner : win_idx;
   assign sel_vld  = (state == PKT) | win_found;
   assign can_load = !s_axis_cc_tvalid | s_axis_cc_tready[0];
   assign out_hs   = s_axis_cc_tvalid & s_axis_cc_tready[0];

   always_comb begin
      sel_oh   = '0;
      tdata_p0 = '0;
      tkeep_p0 = '0;
      tuser_p0 = '0;
      tlast_p0 = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (sel_idx == IDXW'(i)) begin
            sel_oh[i] = 1'b1;
            tdata_p0  = s_axis_cc_tdata_req[i*DATA_WIDTH +: DATA_WIDTH];
            tkeep_p0  = s_axis_cc_tkeep_req[i*KEEP_WIDTH +: KEEP_WIDTH];
            tuser_p0  = s_axis_cc_tuser_req[i*USER_WIDTH +: USER_WIDTH];
            tlast_p0  = s_axis_cc_tlast_req[i];
         end
      end
   end

   assign s_axis_cc_tready_req = (user_reset_n & can_load & sel_vld) ? sel_oh : '0;
   assign in_hs                = |(s_axis_cc_tvalid_req & s_axis_cc_tready_req);

   // Stage boundary: selected beat into the output register, plus arbitration state
   always_ff @(posedge user_clk) begin
      if (!user_reset_n) begin
         state            <= IDLE;
         owner            <= '0;
         last             <= {1'b1, {(N_REQ-1){1'b0}}};
         grant            <= '0;
         pkt_cnt          <= '0;
         s_axis_cc_tvalid <= 1'b0;
         s_axis_cc_tdata  <= '0;
         s_axis_cc_tkeep  <= '0;
         s_axis_cc_tuser  <= '0;
         s_axis_cc_tlast  <= 1'b0;
      end else begin
         if (in_hs) begin
            s_axis_cc_tvalid <= 1'b1;
            s_axis_cc_tdata  <= tdata_p0;
            s_axis_cc_tkeep  <= tkeep_p0;
            s_axis_cc_tuser  <= tuser_p0;
            s_axis_cc_tlast  <= tlast_p0;
         end else if (out_hs) begin
            s_axis_cc_tvalid <= 1'b0;
         end

         if (out_hs && s_axis_cc_tlast) pkt_cnt <= pkt_cnt + 16'd1;

         if (state == IDLE) begin
            if (in_hs) begin
               last <= sel_oh;
               if (!tlast_p0) begin
                  state <= PKT;
                  owner <= win_idx;
                  grant <= sel_oh;
               end
            end
         end else begin
            if (in_hs && tlast_p0) begin
               state <= IDLE;
               grant <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_s_axis_cc_arb.sv
// Bench for s_axis_cc_arb: directed scenarios plus randomized traffic against per-requester
// packet queues, ordering rules and stall rules.
module tb_s_axis_cc_arb;

   localparam int N  = 4;
   localparam int DW = 256;
   localparam int KW = DW/32;
   localparam int UW = 4;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic [UW-1:0] user;
      logic          last;
   } beat_t;

   typedef struct {
      int          req;
      int          beat;
      bit          last;
      int          cyc;
      logic [N-1:0] grant;
   } rec_t;

   logic              user_clk = 1'b0;
   logic              user_reset_n;
   logic [N*DW-1:0]   s_axis_cc_tdata_req;
   logic [N*KW-1:0]   s_axis_cc_tkeep_req;
   logic [N*UW-1:0]   s_axis_cc_tuser_req;
   logic [N-1:0]      s_axis_cc_tlast_req;
   logic [N-1:0]      s_axis_cc_tvalid_req;
   logic [N-1:0]      s_axis_cc_tready_req;
   logic [DW-1:0]     s_axis_cc_tdata;
   logic [KW-1:0]     s_axis_cc_tkeep;
   logic [UW-1:0]     s_axis_cc_tuser;
   logic              s_axis_cc_tlast;
   logic              s_axis_cc_tvalid;
   logic [3:0]        s_axis_cc_tready;
   logic [N-1:0]      grant;
   logic [15:0]       pkt_cnt;

   s_axis_cc_arb #(.N_REQ(N), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) dut (
      .user_clk             (user_clk),
      .user_reset_n         (user_reset_n),
      .s_axis_cc_tdata_req  (s_axis_cc_tdata_req),
      .s_axis_cc_tkeep_req  (s_axis_cc_tkeep_req),
      .s_axis_cc_tuser_req  (s_axis_cc_tuser_req),
      .s_axis_cc_tlast_req  (s_axis_cc_tlast_req),
      .s_axis_cc_tvalid_req (s_axis_cc_tvalid_req),
      .s_axis_cc_tready_req (s_axis_cc_tready_req),
      .s_axis_cc_tdata      (s_axis_cc_tdata),
      .s_axis_cc_tkeep      (s_axis_cc_tkeep),
      .s_axis_cc_tuser      (s_axis_cc_tuser),
      .s_axis_cc_tlast      (s_axis_cc_tlast),
      .s_axis_cc_tvalid     (s_axis_cc_tvalid),
      .s_axis_cc_tready     (s_axis_cc_tready),
      .grant                (grant),
      .pkt_cnt              (pkt_cnt)
   );

   always #5 user_clk = ~user_clk;

   beat_t     src_q[N][$];
   beat_t     exp_q[N][$];
   rec_t      log_q[$];
   bit        rdy_pat[$];
   int        vec = 0;
   int        fail = 0;
   int        cyc = 0;
   int        tot_pkts = 0;
   int        stall_cnt = 0;
   bit        ds_rdy = 1'b1;
   bit        rdy_rand = 1'b0;
   bit        en_rand = 1'b0;
   logic [N-1:0] en = '1;
   bit        open = 1'b0;
   int        open_req = 0;
   bit        prev_stall = 1'b0;
   beat_t     prev_ob;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic add_pkt(input int r, input int len);
      beat_t b;
      for (int k = 0; k < len; k++) begin
         for (int w = 0; w < DW/32; w++) b.data[w*32 +: 32] = $urandom;
         b.data[31:0] = {8'(r), 16'(tot_pkts), 8'(k)};
         b.keep = KW'($urandom);
         b.user = UW'($urandom);
         b.last = (k == len - 1);
         src_q[r].push_back(b);
         exp_q[r].push_back(b);
      end
      tot_pkts++;
   endtask

   task automatic clear_model();
      for (int r = 0; r < N; r++) begin
         src_q[r].delete();
         exp_q[r].delete();
      end
      open = 1'b0;
      prev_stall = 1'b0;
      tot_pkts = 0;
   endtask

   task automatic drive();
      beat_t b;
      for (int r = 0; r < N; r++) begin
         if (src_q[r].size() > 0 && en[r]) begin
            b = src_q[r][0];
            s_axis_cc_tvalid_req[r] = 1'b1;
            s_axis_cc_tdata_req[r*DW +: DW] = b.data;
            s_axis_cc_tkeep_req[r*KW +: KW] = b.keep;
            s_axis_cc_tuser_req[r*UW +: UW] = b.user;
            s_axis_cc_tlast_req[r] = b.last;
         end else begin
            s_axis_cc_tvalid_req[r] = 1'b0;
            s_axis_cc_tlast_req[r] = 1'b0;
         end
      end
      s_axis_cc_tready = {3'($urandom), ds_rdy};
   endtask

   function automatic bit busy();
      for (int r = 0; r < N; r++) if (src_q[r].size() > 0 || exp_q[r].size() > 0) return 1'b1;
      return s_axis_cc_tvalid === 1'b1;
   endfunction

   // One clock: observe at the falling edge, advance sources after the rising edge
   task automatic step();
      beat_t        ob;
      rec_t         rec;
      int           rq;
      logic [N-1:0] hs;
      @(negedge user_clk);
      hs = s_axis_cc_tvalid_req & s_axis_cc_tready_req;
      ob = {s_axis_cc_tdata, s_axis_cc_tkeep, s_axis_cc_tuser, s_axis_cc_tlast};
      if (user_reset_n) begin
         vec++;
         if ($countones(s_axis_cc_tready_req) > 1)
            begin fail++; $display("FAIL ready_onehot: got %b, want at most one bit", s_axis_cc_tready_req); end
         if (s_axis_cc_tvalid && !ds_rdy) begin
            stall_cnt++;
            vec++;
            if (s_axis_cc_tready_req !== '0)
               begin fail++; $display("FAIL stall_ready: got %b, want 0000", s_axis_cc_tready_req); end
         end
         if (prev_stall) begin
            vec++;
            if (ob !== prev_ob)
               begin fail++; $display("FAIL stall_hold: got %h, want %h", ob, prev_ob); end
         end
         prev_stall = s_axis_cc_tvalid && !ds_rdy;
         prev_ob = ob;
         if (s_axis_cc_tvalid && ds_rdy) begin
            rq = int'(ob.data[31:24]);
            vec++;
            if (rq >= N || exp_q[rq].size() == 0) begin
               fail++; $display("FAIL out_orphan: got beat %h from req %0d, want a pending beat", ob.data[31:0], rq);
            end else begin
               if (ob !== exp_q[rq][0])
                  begin fail++; $display("FAIL out_beat: got %h, want %h", ob, exp_q[rq][0]); end
               void'(exp_q[rq].pop_front());
            end
            vec++;
            if (open && rq != open_req)
               begin fail++; $display("FAIL interleave: got req %0d, want req %0d", rq, open_req); end
            open = !ob.last;
            open_req = rq;
            rec.req = rq; rec.beat = int'(ob.data[7:0]); rec.last = ob.last; rec.cyc = cyc; rec.grant = grant;
            log_q.push_back(rec);
         end
      end else begin
         prev_stall = 1'b0;
      end
      @(posedge user_clk);
      #1;
      cyc++;
      for (int r = 0; r < N; r++) if (hs[r] && src_q[r].size() > 0) void'(src_q[r].pop_front());
      if (rdy_pat.size() > 0) ds_rdy = rdy_pat.pop_front();
      else if (rdy_rand) ds_rdy = ($urandom_range(0, 2) != 0);
      else ds_rdy = 1'b1;
      for (int r = 0; r < N; r++) en[r] = en_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      drive();
   endtask

   task automatic drain(input int budget, input string name);
      int n = 0;
      while (busy() && n < budget) begin
         step();
         n++;
      end
      vec++;
      if (n >= budget) begin fail++; $display("FAIL %s_timeout: got %0d cycles still busy, want drained", name, n); end
   endtask

   task automatic do_reset();
      user_reset_n = 1'b0;
      clear_model();
      drive();
      step();
      user_reset_n = 1'b1;
   endtask

   task automatic test_reset();
      add_pkt(0, 1);
      drive();
      @(negedge user_clk);
      vec++; if (s_axis_cc_tvalid !== 1'b0) begin fail++; $display("FAIL rst_tvalid: got %b, want 0", s_axis_cc_tvalid); end
      vec++; if (s_axis_cc_tdata !== '0) begin fail++; $display("FAIL rst_tdata: got %h, want 0", s_axis_cc_tdata); end
      vec++; if (s_axis_cc_tkeep !== '0) begin fail++; $display("FAIL rst_tkeep: got %h, want 0", s_axis_cc_tkeep); end
      vec++; if (s_axis_cc_tuser !== '0) begin fail++; $display("FAIL rst_tuser: got %h, want 0", s_axis_cc_tuser); end
      vec++; if (s_axis_cc_tlast !== 1'b0) begin fail++; $display("FAIL rst_tlast: got %b, want 0", s_axis_cc_tlast); end
      vec++; if (grant !== '0) begin fail++; $display("FAIL rst_grant: got %b, want 0000", grant); end
      vec++; if (pkt_cnt !== 16'd0) begin fail++; $display("FAIL rst_pkt_cnt: got %0d, want 0", pkt_cnt); end
      vec++; if (s_axis_cc_tready_req !== '0) begin fail++; $display("FAIL rst_ready: got %b, want 0000", s_axis_cc_tready_req); end
      @(posedge user_clk);
      #1;
      cyc++;
      user_reset_n = 1'b1;
      log_q.delete();
      drain(50, "reset");
      vec++;
      if (log_q.size() != 1 || log_q[0].req != 0)
         begin fail++; $display("FAIL rst_first_arb: got %0d beats, want 1 beat from req 0", log_q.size()); end
      vec++; if (pkt_cnt !== 16'(tot_pkts)) begin fail++; $display("FAIL rst_pkt_cnt_after: got %0d, want %0d", pkt_cnt, tot_pkts); end
   endtask

   task automatic test_single();
      int t0;
      log_q.delete();
      add_pkt(2, 3);
      drive();
      t0 = cyc;
      drain(50, "single");
      vec++; if (log_q.size() != 3) begin fail++; $display("FAIL single_len: got %0d, want 3", log_q.size()); end
      for (int k = 0; k < 3 && k < log_q.size(); k++) begin
         vec++;
         if (log_q[k].req != 2 || log_q[k].beat != k || log_q[k].last != (k == 2) || log_q[k].cyc != t0 + 1 + k)
            begin fail++; $display("FAIL single_beat%0d: got req %0d beat %0d last %0d cyc %0d, want req 2 beat %0d last %0d cyc %0d",
                                   k, log_q[k].req, log_q[k].beat, log_q[k].last, log_q[k].cyc, k, (k == 2), t0 + 1 + k); end
         vec++;
         if (log_q[k].grant !== ((k < 2) ? 4'b0100 : 4'b0000))
            begin fail++; $display("FAIL single_grant%0d: got %b, want %b", k, log_q[k].grant, (k < 2) ? 4'b0100 : 4'b0000); end
      end
      vec++; if (pkt_cnt !== 16'(tot_pkts)) begin fail++; $display("FAIL single_pkt_cnt: got %0d, want %0d", pkt_cnt, tot_pkts); end
   endtask

   task automatic test_all4();
      do_reset();
      log_q.delete();
      for (int r = 0; r < N; r++) add_pkt(r, 2);
      drive();
      drain(100, "all4");
      vec++; if (log_q.size() != 8) begin fail++; $display("FAIL all4_len: got %0d, want 8", log_q.size()); end
      for (int k = 0; k < 8 && k < log_q.size(); k++) begin
         vec++;
         if (log_q[k].req != k / 2 || log_q[k].cyc != log_q[0].cyc + k)
            begin fail++; $display("FAIL all4_beat%0d: got req %0d cyc %0d, want req %0d cyc %0d",
                                   k, log_q[k].req, log_q[k].cyc, k / 2, log_q[0].cyc + k); end
      end
      vec++; if (pkt_cnt !== 16'd4) begin fail++; $display("FAIL all4_pkt_cnt: got %0d, want 4", pkt_cnt); end
   endtask

   task automatic test_preempt();
      int want [6] = '{1, 1, 1, 1, 0, 0};
      log_q.delete();
      add_pkt(1, 4);
      drive();
      step();
      step();
      add_pkt(0, 2);
      drive();
      drain(100, "preempt");
      vec++; if (log_q.size() != 6) begin fail++; $display("FAIL preempt_len: got %0d, want 6", log_q.size()); end
      for (int k = 0; k < 6 && k < log_q.size(); k++) begin
         vec++;
         if (log_q[k].req != want[k] || log_q[k].cyc != log_q[0].cyc + k)
            begin fail++; $display("FAIL preempt_beat%0d: got req %0d cyc %0d, want req %0d cyc %0d",
                                   k, log_q[k].req, log_q[k].cyc, want[k], log_q[0].cyc + k); end
      end
   endtask

   task automatic test_stall();
      log_q.delete();
      stall_cnt = 0;
      add_pkt(3, 4);
      rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      drive();
      drain(100, "stall");
      vec++; if (log_q.size() != 4) begin fail++; $display("FAIL stall_len: got %0d, want 4", log_q.size()); end
      for (int k = 0; k < 4 && k < log_q.size(); k++) begin
         vec++;
         if (log_q[k].req != 3 || log_q[k].beat != k)
            begin fail++; $display("FAIL stall_beat%0d: got req %0d beat %0d, want req 3 beat %0d", k, log_q[k].req, log_q[k].beat, k); end
      end
      vec++; if (stall_cnt != 2) begin fail++; $display("FAIL stall_cycles: got %0d, want 2", stall_cnt); end
      if (log_q.size() >= 2) begin
         vec++;
         if (log_q[1].cyc - log_q[0].cyc != 3)
            begin fail++; $display("FAIL stall_gap: got %0d, want 3", log_q[1].cyc - log_q[0].cyc); end
      end
   endtask

   task automatic test_alternate();
      log_q.delete();
      for (int k = 0; k < 6; k++) begin
         add_pkt(1, 1);
         add_pkt(3, 1);
      end
      drive();
      drain(100, "alternate");
      vec++; if (log_q.size() != 12) begin fail++; $display("FAIL alt_len: got %0d, want 12", log_q.size()); end
      for (int k = 0; k < 12 && k < log_q.size(); k++) begin
         vec++;
         if (log_q[k].req != ((k % 2 == 0) ? 1 : 3) || log_q[k].cyc != log_q[0].cyc + k)
            begin fail++; $display("FAIL alt_beat%0d: got req %0d cyc %0d, want req %0d cyc %0d",
                                   k, log_q[k].req, log_q[k].cyc, (k % 2 == 0) ? 1 : 3, log_q[0].cyc + k); end
      end
   endtask

   task automatic test_reset_mid();
      int want [3] = '{0, 2, 3};
      add_pkt(1, 6);
      drive();
      repeat (3) step();
      user_reset_n = 1'b0;
      clear_model();
      drive();
      step();
      user_reset_n = 1'b1;
      @(negedge user_clk);
      vec++; if (s_axis_cc_tvalid !== 1'b0) begin fail++; $display("FAIL mid_tvalid: got %b, want 0", s_axis_cc_tvalid); end
      vec++; if (grant !== '0) begin fail++; $display("FAIL mid_grant: got %b, want 0000", grant); end
      vec++; if (pkt_cnt !== 16'd0) begin fail++; $display("FAIL mid_pkt_cnt: got %0d, want 0", pkt_cnt); end
      @(posedge user_clk);
      #1;
      cyc++;
      log_q.delete();
      add_pkt(3, 1);
      add_pkt(2, 1);
      add_pkt(0, 1);
      drive();
      drain(50, "reset_mid");
      vec++; if (log_q.size() != 3) begin fail++; $display("FAIL mid_len: got %0d, want 3", log_q.size()); end
      for (int k = 0; k < 3 && k < log_q.size(); k++) begin
         vec++;
         if (log_q[k].req != want[k])
            begin fail++; $display("FAIL mid_order%0d: got req %0d, want req %0d", k, log_q[k].req, want[k]); end
      end
      vec++; if (pkt_cnt !== 16'd3) begin fail++; $display("FAIL mid_pkt_cnt_after: got %0d, want 3", pkt_cnt); end
   endtask

   task automatic test_random();
      rdy_rand = 1'b1;
      en_rand = 1'b1;
      for (int p = 0; p < 60; p++) add_pkt($urandom_range(0, N - 1), $urandom_range(1, 5));
      drive();
      drain(4000, "random");
      rdy_rand = 1'b0;
      en_rand = 1'b0;
      vec++; if (pkt_cnt !== 16'(tot_pkts)) begin fail++; $display("FAIL random_pkt_cnt: got %0d, want %0d", pkt_cnt, tot_pkts); end
   endtask

   initial begin
      user_reset_n = 1'b0;
      s_axis_cc_tdata_req = '0;
      s_axis_cc_tkeep_req = '0;
      s_axis_cc_tuser_req = '0;
      s_axis_cc_tlast_req = '0;
      s_axis_cc_tvalid_req = '0;
      drive();
      test_reset();
      test_single();
      test_all4();
      test_preempt();
      test_stall();
      test_alternate();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, fail);
      $finish;
   end

endmodule
